// File: rtl/shift_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// shift_arbiter_ctrl
//
// Two-requester round-robin controller sharing one parallel-in/serial-out
// shift register. A granted requester's WIDTH-bit word is sent MSB-first on
// sout. Each bit is held for DIV clocks. A one-cycle done pulse follows the
// last bit of every word. The serial line idles high.
//
// Ports:
//   clk    in   system clock, all state updates on posedge
//   rst    in   synchronous active-high reset
//   req    in   [1:0] request lines, held until the matching gnt is seen
//   data0  in   [WIDTH-1:0] word from requester 0, stable while req[0] high
//   data1  in   [WIDTH-1:0] word from requester 1, stable while req[1] high
//   gnt    out  [1:0] one-hot grant pulse, one cycle after acceptance
//   src    out  index of the requester being served (holds when idle)
//   sout   out  serial data, MSB first, 1 when idle
//   busy   out  high while a word is being shifted
//   done   out  one-cycle pulse after the last bit completes
// -----------------------------------------------------------------------------
module shift_arbiter_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             src,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    // Holds only the bits not yet on sout; the MSB goes straight to sout on load.
    logic [WIDTH-2:0] r_shreg;
    logic [BW-1:0]    r_bit;
    logic [DW-1:0]    r_div;
    logic             r_last;
    logic [1:0]       r_gnt;
    logic             r_src;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;

    logic             w_any;
    logic             w_win;
    logic [WIDTH-1:0] w_win_data;

    assign w_any = |req;
    // On a tie the requester that was not served last wins; otherwise the
    // single active line decides, and req[1] alone identifies it.
    assign w_win      = (req == 2'b11) ? ~r_last : req[1];
    assign w_win_data = w_win ? data1 : data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_div   <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_src   <= 1'b0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gnt  <= 2'b00;
                    r_done <= 1'b0;
                    r_sout <= 1'b1;
                    if (w_any) begin
                        r_shreg <= w_win_data[WIDTH-2:0];
                        r_sout  <= w_win_data[WIDTH-1];
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_src   <= w_win;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_gnt <= 2'b00;
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit   <= '0;
                            r_sout  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_sout  <= r_shreg[WIDTH-2];
                            r_shreg <= r_shreg << 1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_sout  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign src  = r_src;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter_ctrl
//
// Two instances (WIDTH=4 with DIV=1 and DIV=3) are driven by directed vectors.
// A word-level model predicts every output from the acceptance edge, the
// served word and the elapsed cycle count; literal expectations pin the
// model against hand-worked sequences.
// -----------------------------------------------------------------------------
module tb_shift_arbiter_ctrl;

    localparam int W = 4;
    localparam int DIVS [2] = '{1, 3};

    logic       clk;
    logic       rst  [2];
    logic [1:0] req  [2];
    logic [3:0] d0   [2];
    logic [3:0] d1   [2];
    logic [1:0] gnt  [2];
    logic       src  [2];
    logic       sout [2];
    logic       busy [2];
    logic       done [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    shift_arbiter_ctrl #(.WIDTH(W), .DIV(1)) u_a (
        .clk(clk), .rst(rst[0]), .req(req[0]), .data0(d0[0]), .data1(d1[0]),
        .gnt(gnt[0]), .src(src[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0])
    );

    shift_arbiter_ctrl #(.WIDTH(W), .DIV(3)) u_b (
        .clk(clk), .rst(rst[1]), .req(req[1]), .data0(d0[1]), .data1(d1[1]),
        .gnt(gnt[1]), .src(src[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Word-level model: a word accepted at edge t0 occupies edges t0..t0+W*DIV-1,
    // done follows at t0+W*DIV, and the next acceptance may happen at t0+W*DIV+2.
    bit       m_en   [2];
    bit       m_val  [2];
    int       m_t0   [2];
    int       m_next [2];
    logic [3:0] m_word [2];
    logic     m_src  [2];
    logic     m_last [2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_en[i]   = 1'b1;
                m_val[i]  = 1'b0;
                m_next[i] = cyc + 1;
                m_src[i]  = 1'b0;
                m_last[i] = 1'b1;
            end else if (m_en[i] && cyc >= m_next[i] && req[i] != 2'b00) begin
                logic win;
                if (req[i] == 2'b11) win = ~m_last[i];
                else                 win = req[i][1];
                m_val[i]  = 1'b1;
                m_t0[i]   = cyc;
                m_word[i] = win ? d1[i] : d0[i];
                m_src[i]  = win;
                m_last[i] = win;
                m_next[i] = cyc + W * DIVS[i] + 2;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_en[i]) begin
                int   n;
                logic e_busy, e_sout, e_done;
                logic [1:0] e_gnt;
                n      = cyc - m_t0[i];
                e_busy = m_val[i] && (n < W * DIVS[i]);
                e_sout = e_busy ? m_word[i][W - 1 - n / DIVS[i]] : 1'b1;
                e_done = m_val[i] && (n == W * DIVS[i]);
                e_gnt  = (m_val[i] && n == 0) ? (m_src[i] ? 2'b10 : 2'b01) : 2'b00;
                check($sformatf("model_sout_dut%0d", i), int'(sout[i]), int'(e_sout));
                check($sformatf("model_busy_dut%0d", i), int'(busy[i]), int'(e_busy));
                check($sformatf("model_done_dut%0d", i), int'(done[i]), int'(e_done));
                check($sformatf("model_gnt_dut%0d", i),  int'(gnt[i]),  int'(e_gnt));
                check($sformatf("model_src_dut%0d", i),  int'(src[i]),  int'(m_src[i]));
            end
        end
    end

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            req[i] = 2'b00;
            rst[i] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  s4;
        logic [11:0] s12;
        logic [15:0] s16;
        int g_cyc [4];
        int g_src [4];
        int ng, nb, cnt_busy, cnt_done, cnt_zero, cnt_bad;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; req[i] = 2'b00; d0[i] = '0; d1[i] = '0;
        end
        m_en[0] = 1'b0; m_en[1] = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_sout", int'(sout[0]), 1);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_gnt",  int'(gnt[0]),  0);
        check("rst_done", int'(done[0]), 0);
        check("rst_src",  int'(src[0]),  0);

        // Single word 1010 from requester 0, DIV=1
        req[0] = 2'b01; d0[0] = 4'b1010;
        @(negedge clk);
        check("t1_gnt", int'(gnt[0]), 1);
        req[0] = 2'b00;
        s4[3] = sout[0];
        for (int j = 2; j >= 0; j--) begin
            @(negedge clk);
            s4[j] = sout[0];
        end
        check("t1_stream", int'(s4), 4'b1010);
        @(negedge clk);
        check("t1_done", int'(done[0]), 1);
        check("t1_busy", int'(busy[0]), 0);
        check("t1_sout", int'(sout[0]), 1);
        check("t1_src",  int'(src[0]),  0);
        @(negedge clk);
        check("t1_done_off", int'(done[0]), 0);

        // Both requesting continuously: alternation 0,1,0,1
        do_reset();
        req[0] = 2'b11; d0[0] = 4'h9; d1[0] = 4'h6;
        ng = 0; nb = 0; s16 = '0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (gnt[0] != 2'b00 && ng < 4) begin
                g_cyc[ng] = cyc;
                g_src[ng] = int'(gnt[0][1]);
                ng++;
            end
            if (busy[0] && nb < 16) begin
                s16[15 - nb] = sout[0];
                nb++;
            end
        end
        req[0] = 2'b00;
        check("t2_ngrants", ng, 4);
        if (ng == 4) begin
            check("t2_order0", g_src[0], 0);
            check("t2_order1", g_src[1], 1);
            check("t2_order2", g_src[2], 0);
            check("t2_order3", g_src[3], 1);
            check("t2_space01", g_cyc[1] - g_cyc[0], 6);
            check("t2_space12", g_cyc[2] - g_cyc[1], 6);
            check("t2_space23", g_cyc[3] - g_cyc[2], 6);
        end
        check("t2_stream", int'(s16), 16'h9696);
        repeat (8) @(negedge clk);

        // DIV=3, only requester 1 with 0110
        do_reset();
        req[1] = 2'b10; d1[1] = 4'b0110;
        @(negedge clk);
        check("t3_gnt", int'(gnt[1]), 2);
        req[1] = 2'b00;
        s12[11] = sout[1];
        for (int j = 10; j >= 0; j--) begin
            @(negedge clk);
            s12[j] = sout[1];
        end
        check("t3_stream", int'(s12), 12'b000111111000);
        @(negedge clk);
        check("t3_done", int'(done[1]), 1);
        check("t3_src",  int'(src[1]),  1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a word
        do_reset();
        req[0] = 2'b01; d0[0] = 4'b0000;
        @(negedge clk);
        req[0] = 2'b00;
        @(negedge clk);
        check("t4_busy_mid", int'(busy[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("t4_sout", int'(sout[0]), 1);
        check("t4_busy", int'(busy[0]), 0);
        cnt_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done[0]) cnt_done++;
        end
        check("t4_no_done", cnt_done, 0);
        req[0] = 2'b11; d0[0] = 4'h5; d1[0] = 4'h3;
        @(negedge clk);
        req[0] = 2'b00;
        check("t4_gnt_ptr", int'(gnt[0]), 1);
        check("t4_src", int'(src[0]), 0);
        repeat (8) @(negedge clk);

        // All-ones word: line looks idle but busy and done still mark it
        do_reset();
        req[0] = 2'b01; d0[0] = 4'b1111;
        cnt_busy = 0; cnt_done = 0; cnt_zero = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req[0] = 2'b00;
            if (busy[0]) cnt_busy++;
            if (done[0]) cnt_done++;
            if (!sout[0]) cnt_zero++;
        end
        check("t5_busy_cycles", cnt_busy, 4);
        check("t5_done_pulses", cnt_done, 1);
        check("t5_sout_zero",   cnt_zero, 0);

        // Idle with no requests
        do_reset();
        cnt_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (!sout[i] || busy[i] || gnt[i] != 2'b00 || done[i]) cnt_bad++;
        end
        check("t6_idle", cnt_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
